// File: rtl/set_assoc_cache.sv
// 2-way set-associative, write-through, no-write-allocate data cache with multi-word lines
// between the MEM stage and the SRAM controller; saturating hit/miss counters.
module set_assoc_cache #(
  parameter int ADDR_WIDTH   = 19,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           wdata,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int SETS      = 2 ** INDEX_WIDTH;
  localparam int WORDS     = 2 ** OFFSET_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - 2 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int OFF_W     = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;

  localparam logic [OFF_W-1:0]      LAST_WORD = OFF_W'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} state_t;

  // Storage
  logic [31:0]          data_q [2][SETS][WORDS];
  logic [TAG_WIDTH-1:0] tag_q  [2][SETS];
  logic [SETS-1:0]      valid_q [2];
  logic [SETS-1:0]      lru_q;

  // Control state
  state_t                state_q, state_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic                  victim_q, victim_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  // Request decode and lookup
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [OFF_W-1:0]       req_off;
  logic                   hit0, hit1, hit, hit_way;
  logic [31:0]            hit_word;

  // Array write controls
  logic             word_we;
  logic             word_way;
  logic [OFF_W-1:0] word_off;
  logic [31:0]      word_data;
  logic             fill_done;
  logic             lru_we;
  logic             lru_val;

  assign req_tag = address[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx = INDEX_WIDTH'(address >> (2 + OFFSET_WIDTH));
  assign req_off = (OFFSET_WIDTH == 0) ? '0 : OFF_W'(address >> 2);

  assign hit0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_word = data_q[hit_way][req_idx][req_off];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    victim_d    = victim_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ready       = 1'b0;
    rdata       = hit_word;
    word_we     = 1'b0;
    word_way    = hit_way;
    word_off    = req_off;
    word_data   = wdata;
    fill_done   = 1'b0;
    lru_we      = 1'b0;
    lru_val     = 1'b0;

    case (state_q)
      IDLE: begin
        if (MEM_R_EN) begin
          if (hit) begin
            ready     = 1'b1;
            lru_we    = 1'b1;
            lru_val   = ~hit_way;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            // Fill an empty way first; only evict by LRU when the set is full.
            if (!valid_q[0][req_idx])      victim_d = 1'b0;
            else if (!valid_q[1][req_idx]) victim_d = 1'b1;
            else                           victim_d = lru_q[req_idx];
            cnt_d      = '0;
            mem_addr_d = address & ~LINE_MASK;
            state_d    = REFILL;
          end
        end else if (MEM_W_EN) begin
          if (hit) begin
            word_we   = 1'b1;
            lru_we    = 1'b1;
            lru_val   = ~hit_way;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
          mem_addr_d  = address;
          mem_wdata_d = wdata;
          state_d     = WRITE;
        end else begin
          ready = 1'b1;
        end
      end

      REFILL: begin
        if (mem_ready) begin
          word_we   = 1'b1;
          word_way  = victim_q;
          word_off  = cnt_q;
          word_data = mem_rdata;
          if (cnt_q == LAST_WORD) begin
            fill_done = 1'b1;
            lru_we    = 1'b1;
            lru_val   = ~victim_q;
            state_d   = RESP;
          end else begin
            cnt_d      = cnt_q + OFF_W'(1);
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(4);
          end
        end
      end

      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end

      WRITE: begin
        if (mem_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    mem_rd_en_d = (state_d == REFILL);
    mem_wr_en_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q[0]  <= '0;
      valid_q[1]  <= '0;
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      victim_q    <= victim_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (fill_done) valid_q[victim_q][req_idx] <= 1'b1;
      if (lru_we)    lru_q[req_idx] <= lru_val;
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (word_we)   data_q[word_way][req_idx][word_off] <= word_data;
    if (fill_done) tag_q[victim_q][req_idx] <= req_tag;
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
